pixel_ram_arbiter: RTL and testbench
====================================

# pixel_ram_arbiter

Shares the single-port pixel frame RAM among three masters: the ADC acquisition writer (port 0), the pixel de-accumulation process FSM (port 1) and the host readout engine (port 2). Each master requests the RAM and holds it for a complete transaction. The arbiter grants ownership round-robin, muxes the owner's address and write strobe onto the RAM, and returns tagged read-valid pulses. It sits between the three masters and the RAM macro inside the sensor controller core.

## Interface
- `NB_ADC`, 12, RAM data width.
- `NB_ADDR`, 10, RAM address width; covers 24x24 = 576 words.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_req`  in  3  per-port request; bit n belongs to port n. Held high for the whole transaction.
- `o_gnt`  out  3  registered one-hot grant; all zeros when no port owns the RAM.
- `i_addr`  in  3*NB_ADDR  per-port address; port n occupies bits [n*NB_ADDR +: NB_ADDR].
- `i_we`  in  3  per-port write strobe.
- `i_wdata`  in  3*NB_ADC  per-port write data, packed the same way as `i_addr`.
- `o_ram_addr`  out  NB_ADDR  RAM address.
- `o_ram_we`  out  1  RAM write enable.
- `o_ram_wdata`  out  NB_ADC  RAM write data.
- `i_ram_rdata`  in  NB_ADC  RAM read data; 1-cycle read latency.
- `o_rdata`  out  NB_ADC  read data, broadcast to all ports (equals `i_ram_rdata`).
- `o_rvalid`  out  3  one-hot read-valid pulse to the port that issued the read.
- `o_busy`  out  1  high whenever the state is not IDLE.
- `i_clr_err`  in  1  synchronous clear for `o_err`.
- `o_err`  out  1  sticky flag: a port asserted `i_we` while not granted.

## Operation
- FSM states: IDLE, GRANT, TURN.
- **IDLE**
  - If any `i_req` bit is high, select the winner round-robin, starting from `last_owner+1` mod 3.
  - Load `o_gnt` with the winner's one-hot code, set `last_owner` to the winner, go to GRANT.
  - If no request is pending, stay in IDLE.
- **GRANT**
  - The RAM mux follows the owner: `o_ram_addr`/`o_ram_wdata` = owner's `i_addr`/`i_wdata`; `o_ram_we` = owner's `i_we`.
  - When the owner's `i_req` is low: clear `o_gnt` to 0 and go to TURN.
  - Requests from other ports never preempt the owner.
- **TURN**
  - One dead cycle. `o_gnt` = 0, `o_ram_we` = 0. Go to IDLE unconditionally.
- Outside GRANT: `o_ram_we` = 0 and `o_ram_addr` = 0.
- **Read tag**
  - Every cycle in GRANT with owner `i_we` = 0 counts as a read. Register the owner's one-hot code.
  - On the next cycle, `o_rvalid` = the registered code; otherwise `o_rvalid` = 0.
  - The pulse is issued even if the grant has already dropped in that cycle, so the last read before release is still delivered.
- **Error flag**
  - Any `i_we[n]` = 1 with `o_gnt[n]` = 0 sets `o_err` on the next edge. That write is never forwarded to the RAM.
  - `i_clr_err` clears `o_err`. If clear and set coincide, set wins.
- **Round-robin pointer**
  - `last_owner` resets to 2, so port 0 has first priority after reset.
  - Under continuous contention, each port waits at most 2 transactions.
- **Reset** (asynchronous, including mid-transaction)
  - State to IDLE; `o_gnt`, `o_rvalid`, `o_err` = 0; `last_owner` = 2.
  - `o_ram_we` goes to 0 immediately, with no clock edge required.
  - A transaction in flight is dropped; masters must re-request.

## Timing
- Request to grant: `i_req` sampled high at edge t in IDLE gives `o_gnt` high after t.
  - The owner may drive its first address or write in the cycle after `o_gnt` rises.
- Release: owner `i_req` low sampled at edge t gives `o_gnt` = 0 after t (TURN).
  - IDLE follows after t+1; earliest next grant is after t+2.
  - Minimum gap between grants is 2 cycles.
- Read: address presented in GRANT at cycle k gives `o_rdata` and `o_rvalid[owner]` valid in cycle k+1.
- Write: a write presented in GRANT at cycle k is committed by the RAM at edge k.
- Simultaneous requests in IDLE are resolved in one cycle by the round-robin order.
- A single requester re-requesting alone is re-granted after TURN and IDLE; no starvation hold-off applies.

## Test plan
- **Reset state:** assert `rst` = 0 -> `o_gnt` = 000, `o_ram_we` = 0, `o_busy` = 0, `o_err` = 0.
- **Write then read by port 1:** `i_req` = 010; write 0xABC to address 37; read address 37 -> `o_rvalid` = 010 with `o_rdata` = 0xABC one cycle after the read address.
- **Round-robin:** `i_req` = 111 held, each owner releasing after 4 cycles -> grant order 001, 010, 100, 001, with 2 dead cycles between grants.
- **No preemption:** port 2 owns the RAM; port 0 raises `i_req` -> `o_gnt` stays 100 until port 2 drops `i_req`, then `o_gnt` becomes 001 two cycles later.
- **Illegal write:** port 0 pulses `i_we` while `o_gnt` = 010 -> `o_ram_we` stays 0 and `o_err` goes to 1. Assert `i_clr_err` -> `o_err` = 0.
- **Reset mid-write:** pull `rst` low while port 0 has `i_we` = 1 in GRANT -> `o_ram_we` = 0 immediately. After release, port 0 is granted first when all ports request.

Source files
------------

// File: rtl/pixel_ram_arbiter.sv
`default_nettype none
// ============================================================================
// pixel_ram_arbiter
// Round-robin owner arbiter for the single-port pixel frame RAM (3 masters).
// Rev 1.0
// ============================================================================
module pixel_ram_arbiter #(
    parameter int NB_ADC  = 12,
    parameter int NB_ADDR = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           i_req,
    output logic [2:0]           o_gnt,
    input  logic [3*NB_ADDR-1:0] i_addr,
    input  logic [2:0]           i_we,
    input  logic [3*NB_ADC-1:0]  i_wdata,
    output logic [NB_ADDR-1:0]   o_ram_addr,
    output logic                 o_ram_we,
    output logic [NB_ADC-1:0]    o_ram_wdata,
    input  logic [NB_ADC-1:0]    i_ram_rdata,
    output logic [NB_ADC-1:0]    o_rdata,
    output logic [2:0]           o_rvalid,
    output logic                 o_busy,
    input  logic                 i_clr_err,
    output logic                 o_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t       r_state, w_state_nxt;
    logic [2:0]   r_gnt, w_gnt_nxt;
    logic [1:0]   r_last, w_last_nxt;
    logic [2:0]   r_rtag, w_rtag_nxt;
    logic         r_err;

    logic         w_in_grant;
    logic         w_own_req;
    logic         w_own_we;
    logic         w_illegal;
    logic         w_win_vld;
    logic [1:0]   w_win_idx;
    logic [1:0]   w_cand;

    function automatic logic [1:0] f_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [2:0] f_onehot(input logic [1:0] p);
        case (p)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Round-robin search begins at the port after the previous owner.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = 2'd0;
        w_cand    = f_next(r_last);
        for (int k = 0; k < 3; k++) begin
            if (!w_win_vld && i_req[w_cand]) begin
                w_win_vld = 1'b1;
                w_win_idx = w_cand;
            end
            w_cand = f_next(w_cand);
        end
    end

    assign w_in_grant = (r_state == S_GRANT);

    // r_last holds the current owner while in GRANT.
    always_comb begin
        w_own_req   = 1'b0;
        w_own_we    = 1'b0;
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        if (w_in_grant) begin
            case (r_last)
                2'd0: begin
                    w_own_req   = i_req[0];
                    w_own_we    = i_we[0];
                    o_ram_addr  = i_addr[0*NB_ADDR +: NB_ADDR];
                    o_ram_wdata = i_wdata[0*NB_ADC +: NB_ADC];
                end
                2'd1: begin
                    w_own_req   = i_req[1];
                    w_own_we    = i_we[1];
                    o_ram_addr  = i_addr[1*NB_ADDR +: NB_ADDR];
                    o_ram_wdata = i_wdata[1*NB_ADC +: NB_ADC];
                end
                2'd2: begin
                    w_own_req   = i_req[2];
                    w_own_we    = i_we[2];
                    o_ram_addr  = i_addr[2*NB_ADDR +: NB_ADDR];
                    o_ram_wdata = i_wdata[2*NB_ADC +: NB_ADC];
                end
                default: begin
                    w_own_req = 1'b0;
                end
            endcase
        end
    end

    // State is reset asynchronously, so the write strobe drops with rst.
    assign o_ram_we = w_in_grant & w_own_we;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        case (r_state)
            S_IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt = S_GRANT;
                    w_gnt_nxt   = f_onehot(w_win_idx);
                    w_last_nxt  = w_win_idx;
                end
            end
            S_GRANT: begin
                if (!w_own_req) begin
                    w_state_nxt = S_TURN;
                    w_gnt_nxt   = 3'b000;
                end
            end
            S_TURN: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = 3'b000;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = 3'b000;
            end
        endcase
        w_rtag_nxt = (w_in_grant && !w_own_we) ? r_gnt : 3'b000;
    end

    assign w_illegal = |(i_we & ~r_gnt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_gnt   <= 3'b000;
            r_last  <= 2'd2;
            r_rtag  <= 3'b000;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
            r_rtag  <= w_rtag_nxt;
            if (w_illegal) begin
                r_err <= 1'b1;
            end else if (i_clr_err) begin
                r_err <= 1'b0;
            end
        end
    end

    assign o_gnt    = r_gnt;
    assign o_rvalid = r_rtag;
    assign o_rdata  = i_ram_rdata;
    assign o_busy   = (r_state != S_IDLE);
    assign o_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pixel_ram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_pixel_ram_arbiter
// Self-checking bench: vector table for arbitration/error flag, plus read
// scoreboard and hand sequences for RAM access and asynchronous reset.
// Rev 1.0
// ============================================================================
module tb_pixel_ram_arbiter;

    localparam int NB_ADC  = 12;
    localparam int NB_ADDR = 10;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [2:0]           i_req;
    logic [2:0]           o_gnt;
    logic [3*NB_ADDR-1:0] i_addr;
    logic [2:0]           i_we;
    logic [3*NB_ADC-1:0]  i_wdata;
    logic [NB_ADDR-1:0]   o_ram_addr;
    logic                 o_ram_we;
    logic [NB_ADC-1:0]    o_ram_wdata;
    logic [NB_ADC-1:0]    ram_rdata;
    logic [NB_ADC-1:0]    o_rdata;
    logic [2:0]           o_rvalid;
    logic                 o_busy;
    logic                 i_clr_err;
    logic                 o_err;

    always #5 clk = ~clk;

    pixel_ram_arbiter #(
        .NB_ADC  (NB_ADC),
        .NB_ADDR (NB_ADDR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (i_req),
        .o_gnt       (o_gnt),
        .i_addr      (i_addr),
        .i_we        (i_we),
        .i_wdata     (i_wdata),
        .o_ram_addr  (o_ram_addr),
        .o_ram_we    (o_ram_we),
        .o_ram_wdata (o_ram_wdata),
        .i_ram_rdata (ram_rdata),
        .o_rdata     (o_rdata),
        .o_rvalid    (o_rvalid),
        .o_busy      (o_busy),
        .i_clr_err   (i_clr_err),
        .o_err       (o_err)
    );

    // Single-port RAM with one-cycle read latency.
    logic [NB_ADC-1:0] ram [0:1023];
    always @(posedge clk) begin
        if (o_ram_we) ram[o_ram_addr] <= o_ram_wdata;
        ram_rdata <= ram[o_ram_addr];
    end

    typedef struct {
        logic [2:0] req;
        logic [2:0] we;
        logic       clr;
        logic       exp_ram_we;
        logic [2:0] exp_gnt;
        logic       exp_busy;
        logic       exp_err;
    } vec_t;

    typedef struct {
        logic [2:0]        tag;
        logic [NB_ADC-1:0] data;
    } rd_exp_t;

    vec_t    vecs[$];
    rd_exp_t sb[$];
    int      n_cmp = 0;
    int      n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] req, input logic [2:0] we, input logic clr,
                       input logic rwe, input logic [2:0] gnt, input logic busy, input logic err);
        vec_t v;
        v.req = req; v.we = we; v.clr = clr;
        v.exp_ram_we = rwe; v.exp_gnt = gnt; v.exp_busy = busy; v.exp_err = err;
        vecs.push_back(v);
    endtask

    task automatic set_port(input int p, input logic [NB_ADDR-1:0] a, input logic [NB_ADC-1:0] d);
        i_addr[p*NB_ADDR +: NB_ADDR] = a;
        i_wdata[p*NB_ADC +: NB_ADC]  = d;
    endtask

    task automatic pop_check(input string name);
        rd_exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s: got rvalid %0h with no read pending, expected a queued read", name, o_rvalid);
        end else begin
            e = sb.pop_front();
            check({name, "_rvalid"}, {29'd0, o_rvalid}, {29'd0, e.tag});
            check({name, "_rdata"}, {20'd0, o_rdata}, {20'd0, e.data});
        end
    endtask

    initial begin
        rst       = 1'b0;
        i_req     = '0;
        i_we      = '0;
        i_clr_err = 1'b0;
        i_addr    = '0;
        i_wdata   = '0;
        set_port(0, 10'd1, 12'h111);
        set_port(1, 10'd2, 12'h222);
        set_port(2, 10'd3, 12'h333);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt",    {29'd0, o_gnt},    32'd0);
        check("rst_ram_we", {31'd0, o_ram_we}, 32'd0);
        check("rst_busy",   {31'd0, o_busy},   32'd0);
        check("rst_err",    {31'd0, o_err},    32'd0);
        check("rst_rvalid", {29'd0, o_rvalid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Round-robin under full contention, 2 dead cycles between grants
        //   req     we      clr  rwe  gnt     busy err
        add(3'b111, 3'b000, 0,   0,   3'b001, 1,   0);
        add(3'b111, 3'b000, 0,   0,   3'b001, 1,   0);
        add(3'b111, 3'b000, 0,   0,   3'b001, 1,   0);
        add(3'b111, 3'b000, 0,   0,   3'b001, 1,   0);
        add(3'b110, 3'b000, 0,   0,   3'b000, 1,   0);
        add(3'b111, 3'b000, 0,   0,   3'b000, 0,   0);
        add(3'b111, 3'b000, 0,   0,   3'b010, 1,   0);
        add(3'b111, 3'b000, 0,   0,   3'b010, 1,   0);
        add(3'b111, 3'b000, 0,   0,   3'b010, 1,   0);
        add(3'b111, 3'b000, 0,   0,   3'b010, 1,   0);
        add(3'b101, 3'b000, 0,   0,   3'b000, 1,   0);
        add(3'b111, 3'b000, 0,   0,   3'b000, 0,   0);
        add(3'b111, 3'b000, 0,   0,   3'b100, 1,   0);
        add(3'b111, 3'b000, 0,   0,   3'b100, 1,   0);
        add(3'b111, 3'b000, 0,   0,   3'b100, 1,   0);
        add(3'b111, 3'b000, 0,   0,   3'b100, 1,   0);
        add(3'b011, 3'b000, 0,   0,   3'b000, 1,   0);
        add(3'b111, 3'b000, 0,   0,   3'b000, 0,   0);
        add(3'b111, 3'b000, 0,   0,   3'b001, 1,   0);
        add(3'b110, 3'b000, 0,   0,   3'b000, 1,   0);
        add(3'b000, 3'b000, 0,   0,   3'b000, 0,   0);
        add(3'b000, 3'b000, 0,   0,   3'b000, 0,   0);
        // No preemption: port 2 owns, port 0 waits
        add(3'b100, 3'b000, 0,   0,   3'b100, 1,   0);
        add(3'b101, 3'b000, 0,   0,   3'b100, 1,   0);
        add(3'b101, 3'b000, 0,   0,   3'b100, 1,   0);
        add(3'b001, 3'b000, 0,   0,   3'b000, 1,   0);
        add(3'b001, 3'b000, 0,   0,   3'b000, 0,   0);
        add(3'b001, 3'b000, 0,   0,   3'b001, 1,   0);
        add(3'b000, 3'b000, 0,   0,   3'b000, 1,   0);
        add(3'b000, 3'b000, 0,   0,   3'b000, 0,   0);
        // Illegal writes and sticky error flag, port 1 owns
        add(3'b010, 3'b000, 0,   0,   3'b010, 1,   0);
        add(3'b010, 3'b001, 0,   0,   3'b010, 1,   1);
        add(3'b010, 3'b000, 0,   0,   3'b010, 1,   1);
        add(3'b010, 3'b000, 1,   0,   3'b010, 1,   0);
        add(3'b010, 3'b010, 0,   1,   3'b010, 1,   0);
        add(3'b010, 3'b100, 1,   0,   3'b010, 1,   1);
        add(3'b010, 3'b000, 1,   0,   3'b010, 1,   0);
        add(3'b000, 3'b000, 0,   0,   3'b000, 1,   0);
        add(3'b000, 3'b000, 0,   0,   3'b000, 0,   0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            i_req     = vecs[i].req;
            i_we      = vecs[i].we;
            i_clr_err = vecs[i].clr;
            #1;
            check($sformatf("vec%0d_ram_we", i), {31'd0, o_ram_we}, {31'd0, vecs[i].exp_ram_we});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_gnt", i),  {29'd0, o_gnt},  {29'd0, vecs[i].exp_gnt});
            check($sformatf("vec%0d_busy", i), {31'd0, o_busy}, {31'd0, vecs[i].exp_busy});
            check($sformatf("vec%0d_err", i),  {31'd0, o_err},  {31'd0, vecs[i].exp_err});
        end

        // Port 1: write 37 and last word 575, read both back; last read
        // coincides with request release.
        @(negedge clk);
        i_we = '0; i_clr_err = 1'b0;
        i_req = 3'b010;
        set_port(1, 10'd37, 12'h000);
        @(posedge clk); #1;
        check("p1_gnt", {29'd0, o_gnt}, 32'h2);
        @(negedge clk);
        i_we = 3'b010;
        set_port(1, 10'd37, 12'hABC);
        #1;
        check("p1_wr_we",    {31'd0, o_ram_we},    32'd1);
        check("p1_wr_addr",  {22'd0, o_ram_addr},  32'd37);
        check("p1_wr_wdata", {20'd0, o_ram_wdata}, 32'hABC);
        @(negedge clk);
        set_port(1, 10'd575, 12'h5A5);
        #1;
        check("p1_wr575_addr", {22'd0, o_ram_addr}, 32'd575);
        @(negedge clk);
        i_we = 3'b000;
        set_port(1, 10'd37, 12'h000);
        sb.push_back('{tag: 3'b010, data: 12'hABC});
        #1;
        check("p1_rd_we", {31'd0, o_ram_we}, 32'd0);
        @(posedge clk); #1;
        pop_check("p1_rd37");
        @(negedge clk);
        set_port(1, 10'd575, 12'h000);
        i_req = 3'b000;
        sb.push_back('{tag: 3'b010, data: 12'h5A5});
        @(posedge clk); #1;
        check("p1_release_gnt", {29'd0, o_gnt}, 32'd0);
        pop_check("p1_rd575_after_release");
        @(posedge clk); #1;
        check("p1_turn_rvalid", {29'd0, o_rvalid}, 32'd0);
        @(posedge clk); #1;
        check("p1_idle_busy", {31'd0, o_busy}, 32'd0);

        // Reset in the middle of a port 0 write
        @(negedge clk);
        i_req = 3'b001;
        @(posedge clk); #1;
        check("p0_gnt", {29'd0, o_gnt}, 32'h1);
        @(negedge clk);
        i_we = 3'b001;
        set_port(0, 10'd100, 12'h777);
        #1;
        check("p0_wr_we", {31'd0, o_ram_we}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_ram_we", {31'd0, o_ram_we}, 32'd0);
        check("async_rst_gnt",    {29'd0, o_gnt},    32'd0);
        check("async_rst_busy",   {31'd0, o_busy},   32'd0);
        @(negedge clk);
        i_we  = 3'b000;
        i_req = 3'b000;
        rst   = 1'b1;
        #1;
        check("async_rst_err",    {31'd0, o_err},    32'd0);
        check("async_rst_rvalid", {29'd0, o_rvalid}, 32'd0);
        @(negedge clk);
        i_req = 3'b111;
        @(posedge clk); #1;
        check("post_rst_first_gnt", {29'd0, o_gnt}, 32'h1);
        @(negedge clk);
        i_req = 3'b000;
        @(posedge clk); #1;
        check("post_rst_release_gnt", {29'd0, o_gnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
